// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI shift controller: the controller FSM state
// encoding, the four SPI mode constants ({CPOL, CPHA}) and small helpers to
// pull the polarity / phase bits out of a mode word.
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic mode_cpha(input logic [1:0] m);
    return m[0];
  endfunction

  function automatic logic mode_cpol(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
// Transmit / receive shift datapath of the SPI controller. The transmit word
// is loaded in parallel and walked out on mosi one bit per tx_shift; miso is
// collected one bit per rx_sample. Both registers move in the same direction
// so the received word comes out in the same bit order it was sent.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture load_data into tx_sr and present its first bit
//   load_data   : word to transmit
//   tx_shift    : advance tx_sr and present the next bit on mosi
//   rx_sample   : shift miso into rx_sr
//   miso        : serial data in
//   mosi        : serial data out (registered)
//   rx_word     : current contents of rx_sr
// ---------------------------------------------------------------------------
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_shift,
  input  logic              rx_sample,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_word
);

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;

  // mosi is taken from the bit that becomes the new head of tx_sr, so the
  // pin changes in the same cycle as the register rather than one later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr <= '0;
      mosi  <= 1'b0;
    end else if (load) begin
      tx_sr <= load_data;
      mosi  <= MSB_FIRST ? load_data[DATA_W-1] : load_data[0];
    end else if (tx_shift) begin
      if (MSB_FIRST) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        mosi  <= tx_sr[DATA_W-2];
      end else begin
        tx_sr <= {1'b0, tx_sr[DATA_W-1:1]};
        mosi  <= tx_sr[1];
      end
    end
  end

  // rx_sr starts clean on every transfer so a stale word never leaks through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr <= '0;
    end else if (load) begin
      rx_sr <= '0;
    end else if (rx_sample) begin
      if (MSB_FIRST) begin
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end else begin
        rx_sr <= {miso, rx_sr[DATA_W-1:1]};
      end
    end
  end

  assign rx_word = rx_sr;

endmodule

// File: rtl/spi_shift_ctrl.sv
// ---------------------------------------------------------------------------
// spi_shift_ctrl
// SPI master transfer controller. Sequences one DATA_W-bit full-duplex
// transfer per accepted start, driven by the strobe pulses of an external
// baud generator (one strobe per SCLK half-period). The FSM and SCLK edge
// counter live here; the shift registers live in spi_shift_reg.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   start       : transfer request, only honoured in IDLE
//   tx_data     : word to transmit, captured on an accepted start
//   mode        : {CPOL, CPHA}, captured on an accepted start
//   strobe      : half-period pulse from the baud generator
//   miso        : serial data in
//   brg_en      : runs the baud generator counter
//   sclk_en     : lets the baud generator toggle SCLK
//   mode_o      : captured mode, fed back to the baud generator
//   mosi        : serial data out (registered)
//   cs_n        : active-low chip select (registered)
//   busy        : high whenever the FSM is not in IDLE
//   done        : one-cycle pulse at the end of a transfer
//   rx_data     : received word, held until the next done
// ---------------------------------------------------------------------------
module spi_shift_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  input  logic              strobe,
  input  logic              miso,
  output logic              brg_en,
  output logic              sclk_en,
  output logic [1:0]        mode_o,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int                EDGE_W    = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state, state_nxt;
  logic [EDGE_W-1:0] edge_cnt, edge_cnt_nxt;
  logic              cs_n_nxt, brg_en_nxt, sclk_en_nxt;
  logic [1:0]        mode_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic [DATA_W-1:0] rx_word;
  logic              load, tx_shift, rx_sample;
  logic              lead_edge, last_edge;

  // Even counts are leading SCLK edges, odd counts trailing ones.
  assign lead_edge = ~edge_cnt[0];
  assign last_edge = (edge_cnt == LAST_EDGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      cs_n     <= 1'b1;
      brg_en   <= 1'b0;
      sclk_en  <= 1'b0;
      mode_o   <= MODE0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_cnt_nxt;
      cs_n     <= cs_n_nxt;
      brg_en   <= brg_en_nxt;
      sclk_en  <= sclk_en_nxt;
      mode_o   <= mode_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

  // The phase decisions use the captured mode_o, never the live mode input,
  // so mode changes during a transfer cannot disturb it. The SETUP strobe is
  // not an SCLK edge: it only arms sclk_en, and edge 0 is the next strobe.
  always_comb begin
    state_nxt    = state;
    edge_cnt_nxt = edge_cnt;
    cs_n_nxt     = cs_n;
    brg_en_nxt   = brg_en;
    sclk_en_nxt  = sclk_en;
    mode_nxt     = mode_o;
    rx_data_nxt  = rx_data;
    load         = 1'b0;
    tx_shift     = 1'b0;
    rx_sample    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SETUP;
          load         = 1'b1;
          mode_nxt     = mode;
          cs_n_nxt     = 1'b0;
          brg_en_nxt   = 1'b1;
          edge_cnt_nxt = '0;
        end
      end

      SETUP: begin
        if (strobe) begin
          state_nxt   = XFER;
          sclk_en_nxt = 1'b1;
        end
      end

      XFER: begin
        if (strobe) begin
          if (mode_cpha(mode_o)) begin
            // First bit is already on mosi for edge 0; later leading edges
            // advance it, trailing edges sample.
            tx_shift  = lead_edge && (edge_cnt != '0);
            rx_sample = ~lead_edge;
          end else begin
            // The final trailing edge must not push a bit past the word.
            rx_sample = lead_edge;
            tx_shift  = ~lead_edge && ~last_edge;
          end
          if (last_edge) begin
            state_nxt   = HOLD;
            sclk_en_nxt = 1'b0;
          end else begin
            edge_cnt_nxt = edge_cnt + EDGE_W'(1);
          end
        end
      end

      HOLD: begin
        if (strobe) begin
          state_nxt   = DONE;
          cs_n_nxt    = 1'b1;
          brg_en_nxt  = 1'b0;
          rx_data_nxt = rx_word;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  spi_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(tx_data),
    .tx_shift (tx_shift),
    .rx_sample(rx_sample),
    .miso     (miso),
    .mosi     (mosi),
    .rx_word  (rx_word)
  );

endmodule

// File: doc/spi_shift_ctrl.md
SPI_SHIFT_CTRL -- requirements
Module: spi_shift_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_W, default 8: the number of bits per transfer.
REQ-003 Parameter MSB_FIRST, default 1: 1 shifts the MSB first, 0 shifts the LSB first.
REQ-004 Port clk, input, 1: system clock. All logic is on the rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: single-cycle transfer request. Sampled only in IDLE.
REQ-007 Port tx_data, input, DATA_W: word to transmit. Captured on an accepted start.
REQ-008 Port mode, input, 2: SPI mode, where mode[1] is CPOL and mode[0] is CPHA. Captured on an accepted start.
REQ-009 Port strobe, input, 1: single-cycle pulse from the baud generator, one per SCLK half-period.
REQ-010 Port miso, input, 1: serial data in.
REQ-011 Port brg_en, output, 1: enables the baud generator counter.
REQ-012 Port sclk_en, output, 1: allows the baud generator to toggle SCLK.
REQ-013 Port mode_o, output, 2: captured mode, fed to the baud generator.
REQ-014 Port mosi, output, 1: serial data out. Registered.
REQ-015 Port cs_n, output, 1: active-low chip select. Registered.
REQ-016 Port busy, output, 1: high in every state except IDLE.
REQ-017 Port done, output, 1: single-cycle pulse at the end of a transfer.
REQ-018 Port rx_data, output, DATA_W: received word. Holds its value until the next done.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, SETUP, XFER, HOLD, DONE.
REQ-020 IDLE: a start high moves the FSM to SETUP on the next cycle. In the same cycle it loads tx_sr <= tx_data and mode_o <= mode, drives cs_n <= 0 and brg_en <= 1, and clears edge_cnt.
REQ-021 SETUP: mosi presents the first bit (tx_data[DATA_W-1] if MSB_FIRST, else tx_data[0]). On the first strobe the FSM moves to XFER with sclk_en <= 1.
REQ-022 XFER: each strobe increments edge_cnt over the range 0..2*DATA_W-1. An even edge_cnt is a leading SCLK edge; an odd edge_cnt is a trailing edge.
REQ-023 CPHA=0: MISO SHALL be sampled into rx_sr on even edges. The tx_sr shift and the mosi update SHALL occur on odd edges, except on the final edge.
REQ-024 CPHA=1: the tx_sr shift and the mosi update SHALL occur on even edges, except edge 0, where mosi keeps the first bit. MISO SHALL be sampled on odd edges.
REQ-025 The rx_sr shift direction SHALL follow MSB_FIRST, so that rx_data equals the transmitted bit order.
REQ-026 On the strobe with edge_cnt = 2*DATA_W-1, the FSM SHALL move to HOLD and drive sclk_en <= 0.
REQ-027 HOLD: on the next strobe the FSM SHALL move to DONE, drive cs_n <= 1 and brg_en <= 0, and load rx_data <= rx_sr.
REQ-028 DONE: done is high for exactly 1 cycle, then the FSM returns to IDLE.
REQ-029 A start asserted in DONE SHALL be ignored. The next transfer is accepted in IDLE, so transfers are separated by a minimum of 1 IDLE cycle.
REQ-030 A start asserted while busy SHALL be ignored and SHALL have no side effect.
REQ-031 Changes to tx_data or mode while busy SHALL NOT affect the transfer in progress.
REQ-032 A strobe in IDLE or DONE SHALL be ignored.
REQ-033 edge_cnt SHALL be $clog2(2*DATA_W) bits wide and SHALL never wrap inside a transfer.

Reset
REQ-034 While rst is high, the FSM SHALL be in IDLE with these output values:
  - cs_n = 1
  - mosi = 0
  - busy = 0
  - done = 0
  - brg_en = 0
  - sclk_en = 0
  - mode_o = 0
  - rx_data = 0
REQ-035 While rst is high, tx_sr, rx_sr and edge_cnt SHALL be 0.
REQ-036 A reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously). No done pulse is issued and rx_data is cleared.

Structure
REQ-037 A shared package spi_pkg SHALL hold the FSM state encoding and the SPI mode constants MODE0..MODE3.
REQ-038 The shift datapath (tx_sr, rx_sr, mosi, MSB_FIRST handling) SHALL be one sub-module, spi_shift_reg. The FSM and edge counter remain in spi_shift_ctrl.
REQ-039 The bench SHALL instantiate spi_shift_ctrl together with the existing baud-rate generator, with its strobe output connected to strobe.

Verification
REQ-040 Mode 0, DATA_W=8, tx_data=8'hA5, miso looped to mosi -> mosi carries 1,0,1,0,0,1,0,1; exactly 16 strobes occur with sclk_en high; done is pulsed once; rx_data = 8'hA5.
REQ-041 Modes 1, 2 and 3 with tx_data=8'h3C and a slave model returning 8'hC3 -> rx_data = 8'hC3 in each mode; mosi is stable at every sampling edge.
REQ-042 start pulsed again 5 cycles after the first start, with tx_data changed to 8'hFF -> the first transfer completes unchanged; exactly one done.
REQ-043 rst asserted on edge 7 -> cs_n = 1, busy = 0 and rx_data = 0 in the same cycle; no done; a following start produces a clean transfer.
REQ-044 MSB_FIRST=0, tx_data=8'h01 -> the first mosi bit is 1; rx_data = 8'h01.
REQ-045 Back-to-back transfers 8'h12 then 8'h34 -> cs_n goes high for at least 1 cycle between them; busy drops for at least 1 IDLE cycle between them.
